// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Integer execution unit at the receiving end of the reservation-station
//   issue port. Each issued op is evaluated combinationally in its issue
//   cycle. The result is written into a DEPTH-entry result FIFO. The FIFO head
//   drives the ALU common-data-bus port and is held there until cdb_grant.
//
//   Handshakes:
//     issue : alu_enable is qualified by rdy. The op is accepted when the FIFO
//             has room, or when the head is being granted in the same cycle.
//             A rejected issue is dropped. The RS uses alu_full to avoid
//             issuing into a full unit.
//     cdb   : alu_broadcast is high while the FIFO is non-empty. The head
//             fields stay stable until a cycle in which cdb_grant && rdy.
//             That cycle pops the head.
//   A flush (rst or jump_wrong) empties the FIFO whatever the state of rdy,
//   and discards any issue in the same cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; all state holds while low
//   jump_wrong          misprediction flush
//   alu_enable, to_alu_*  issue port from the reservation station
//   alu_full            FIFO holds DEPTH entries
//   cdb_grant           CDB consumed the head this cycle
//   alu_broadcast       head valid
//   alu_cbd_value, alu_update_rename, alu_is_jump, alu_jump_taken,
//   alu_jump_target     head result fields (zero while empty)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int DEPTH     = 2,
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 jump_wrong,
    input  logic                 alu_enable,
    input  logic [5:0]           to_alu_op,
    input  logic [31:0]          to_alu_rs1_value,
    input  logic [31:0]          to_alu_rs2_value,
    input  logic [31:0]          to_alu_imm,
    input  logic [31:0]          to_alu_pc,
    input  logic [ROB_IDX_W-1:0] to_alu_rd_rename,
    output logic                 alu_full,
    input  logic                 cdb_grant,
    output logic                 alu_broadcast,
    output logic [31:0]          alu_cbd_value,
    output logic [ROB_IDX_W-1:0] alu_update_rename,
    output logic                 alu_is_jump,
    output logic                 alu_jump_taken,
    output logic [31:0]          alu_jump_target
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] OP_ADD   = 6'd1,  OP_SUB   = 6'd2,  OP_AND   = 6'd3;
    localparam logic [5:0] OP_OR    = 6'd4,  OP_XOR   = 6'd5,  OP_SLL   = 6'd6;
    localparam logic [5:0] OP_SRL   = 6'd7,  OP_SRA   = 6'd8,  OP_SLT   = 6'd9;
    localparam logic [5:0] OP_SLTU  = 6'd10, OP_ADDI  = 6'd11, OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13, OP_XORI  = 6'd14, OP_SLLI  = 6'd15;
    localparam logic [5:0] OP_SRLI  = 6'd16, OP_SRAI  = 6'd17, OP_SLTI  = 6'd18;
    localparam logic [5:0] OP_SLTIU = 6'd19, OP_LUI   = 6'd20, OP_AUIPC = 6'd21;
    localparam logic [5:0] OP_JAL   = 6'd22, OP_JALR  = 6'd23, OP_BEQ   = 6'd24;
    localparam logic [5:0] OP_BNE   = 6'd25, OP_BLT   = 6'd26, OP_BGE   = 6'd27;
    localparam logic [5:0] OP_BLTU  = 6'd28, OP_BGEU  = 6'd29;

    // ------------------------------------------------------------------
    // Combinational execute
    // ------------------------------------------------------------------
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        eq;
    logic [31:0] res_value;
    logic        res_jump;
    logic        res_taken;
    logic [31:0] res_target;

    assign op_a  = to_alu_rs1_value;
    // R-type ops (1..10) take rs2. Every other op uses the immediate as
    // its second operand.
    assign op_b  = (to_alu_op >= OP_ADD && to_alu_op <= OP_SLTU) ? to_alu_rs2_value : to_alu_imm;
    assign shamt = op_b[4:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;
    assign eq    = op_a == op_b;

    always_comb begin
        res_value  = '0;
        res_jump   = 1'b0;
        res_taken  = 1'b0;
        res_target = to_alu_pc + 32'd4;
        case (to_alu_op)
            OP_ADD,  OP_ADDI:  res_value = op_a + op_b;
            OP_SUB:            res_value = op_a - op_b;
            OP_AND,  OP_ANDI:  res_value = op_a & op_b;
            OP_OR,   OP_ORI:   res_value = op_a | op_b;
            OP_XOR,  OP_XORI:  res_value = op_a ^ op_b;
            OP_SLL,  OP_SLLI:  res_value = op_a << shamt;
            OP_SRL,  OP_SRLI:  res_value = op_a >> shamt;
            OP_SRA,  OP_SRAI:  res_value = $signed(op_a) >>> shamt;
            OP_SLT,  OP_SLTI:  res_value = {31'd0, lt_s};
            OP_SLTU, OP_SLTIU: res_value = {31'd0, lt_u};
            OP_LUI:            res_value = to_alu_imm;
            OP_AUIPC:          res_value = to_alu_pc + to_alu_imm;
            OP_JAL: begin
                res_value  = to_alu_pc + 32'd4;
                res_jump   = 1'b1;
                res_taken  = 1'b1;
                res_target = to_alu_pc + to_alu_imm;
            end
            OP_JALR: begin
                res_value  = to_alu_pc + 32'd4;
                res_jump   = 1'b1;
                res_taken  = 1'b1;
                res_target = (op_a + to_alu_imm) & ~32'd1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                res_jump   = 1'b1;
                res_target = to_alu_pc + to_alu_imm;
                // Branches compare rs1 with rs2, not with the immediate.
                case (to_alu_op)
                    OP_BEQ:  res_taken = to_alu_rs1_value == to_alu_rs2_value;
                    OP_BNE:  res_taken = to_alu_rs1_value != to_alu_rs2_value;
                    OP_BLT:  res_taken = $signed(to_alu_rs1_value) < $signed(to_alu_rs2_value);
                    OP_BGE:  res_taken = $signed(to_alu_rs1_value) >= $signed(to_alu_rs2_value);
                    OP_BLTU: res_taken = to_alu_rs1_value < to_alu_rs2_value;
                    default: res_taken = to_alu_rs1_value >= to_alu_rs2_value;
                endcase
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [31:0]          value_mem  [DEPTH];
    logic [ROB_IDX_W-1:0] rename_mem [DEPTH];
    logic                 jump_mem   [DEPTH];
    logic                 taken_mem  [DEPTH];
    logic [31:0]          target_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             flush;
    logic             pop;
    logic             push;

    assign flush         = rst | jump_wrong;
    assign alu_broadcast = count != '0;
    assign alu_full      = count == CNT_W'(DEPTH);
    assign pop           = alu_broadcast & cdb_grant & rdy;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push          = alu_enable & rdy & (~alu_full | pop);

    always_ff @(posedge clk) begin
        if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The payload needs no reset. Stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (!flush && push) begin
            value_mem[tail]  <= res_value;
            rename_mem[tail] <= to_alu_rd_rename;
            jump_mem[tail]   <= res_jump;
            taken_mem[tail]  <= res_taken;
            target_mem[tail] <= res_target;
        end
    end

    // Head fields are forced to zero while the FIFO is empty.
    assign alu_cbd_value     = alu_broadcast ? value_mem[head]  : '0;
    assign alu_update_rename = alu_broadcast ? rename_mem[head] : '0;
    assign alu_is_jump       = alu_broadcast & jump_mem[head];
    assign alu_jump_taken    = alu_broadcast & taken_mem[head];
    assign alu_jump_target   = alu_broadcast ? target_mem[head] : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Directed scenarios followed by randomized traffic. A behavioural model
//   keeps the expected FIFO contents in a queue. Each result is computed
//   from the instruction semantics.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
  localparam int ROB_IDX_W = 5;
  localparam int DEPTH     = 2;

  typedef struct packed {
    logic [31:0]          value;
    logic [ROB_IDX_W-1:0] tag;
    logic                 jump;
    logic                 taken;
    logic [31:0]          target;
  } res_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 rdy = 1'b1;
  logic                 jump_wrong = 1'b0;
  logic                 alu_enable = 1'b0;
  logic [5:0]           to_alu_op = '0;
  logic [31:0]          to_alu_rs1_value = '0;
  logic [31:0]          to_alu_rs2_value = '0;
  logic [31:0]          to_alu_imm = '0;
  logic [31:0]          to_alu_pc = '0;
  logic [ROB_IDX_W-1:0] to_alu_rd_rename = '0;
  logic                 cdb_grant = 1'b0;
  logic                 alu_full;
  logic                 alu_broadcast;
  logic [31:0]          alu_cbd_value;
  logic [ROB_IDX_W-1:0] alu_update_rename;
  logic                 alu_is_jump;
  logic                 alu_jump_taken;
  logic [31:0]          alu_jump_target;

  alu_exec_unit #(.DEPTH(DEPTH), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .alu_enable(alu_enable), .to_alu_op(to_alu_op),
    .to_alu_rs1_value(to_alu_rs1_value), .to_alu_rs2_value(to_alu_rs2_value),
    .to_alu_imm(to_alu_imm), .to_alu_pc(to_alu_pc),
    .to_alu_rd_rename(to_alu_rd_rename), .alu_full(alu_full),
    .cdb_grant(cdb_grant), .alu_broadcast(alu_broadcast),
    .alu_cbd_value(alu_cbd_value), .alu_update_rename(alu_update_rename),
    .alu_is_jump(alu_is_jump), .alu_jump_taken(alu_jump_taken),
    .alu_jump_target(alu_jump_target)
  );

  // scoreboard
  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   flushed_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference semantics. I-type ops are folded onto their R-type
  // counterparts, with the immediate used as the second operand.
  function automatic res_t ref_calc(input int op, input logic [31:0] a, input logic [31:0] rs2,
                                    input logic [31:0] imm, input logic [31:0] pc,
                                    input logic [ROB_IDX_W-1:0] tag);
    res_t        r;
    logic [31:0] b;
    logic [4:0]  sh;
    int          kind;
    r        = '0;
    r.tag    = tag;
    r.target = pc + 32'd4;
    b        = (op >= 1 && op <= 10) ? rs2 : imm;
    sh       = b[4:0];
    kind     = op;
    if (op == 11) kind = 1;
    else if (op >= 12 && op <= 19) kind = op - 9;
    case (kind)
      1:  r.value = a + b;
      2:  r.value = a - b;
      3:  r.value = a & b;
      4:  r.value = a | b;
      5:  r.value = a ^ b;
      6:  r.value = a << sh;
      7:  r.value = a >> sh;
      8:  r.value = $signed(a) >>> sh;
      9:  r.value = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      10: r.value = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
      20: r.value = imm;
      21: r.value = pc + imm;
      22: begin r.value = pc + 32'd4; r.jump = 1; r.taken = 1; r.target = pc + imm; end
      23: begin r.value = pc + 32'd4; r.jump = 1; r.taken = 1; r.target = (a + imm) & 32'hFFFF_FFFE; end
      24, 25, 26, 27, 28, 29: begin
        r.jump   = 1;
        r.target = pc + imm;
        case (kind)
          24: r.taken = (a == rs2);
          25: r.taken = (a != rs2);
          26: r.taken = (int'(a) < int'(rs2));
          27: r.taken = (int'(a) >= int'(rs2));
          28: r.taken = ({1'b0, a} < {1'b0, rs2});
          default: r.taken = ({1'b0, a} >= {1'b0, rs2});
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  // One clock: compare outputs with the model, advance the model with the
  // inputs currently driven, then cross the edge and return 1 time unit after it.
  task automatic step();
    res_t h;
    bit   pop;
    bit   acc;
    @(negedge clk);
    check("broadcast", {31'd0, alu_broadcast}, {31'd0, exp_q.size() != 0});
    check("full", {31'd0, alu_full}, {31'd0, exp_q.size() == DEPTH});
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("value", alu_cbd_value, h.value);
      check("rename", {27'd0, alu_update_rename}, {27'd0, h.tag});
      check("is_jump", {31'd0, alu_is_jump}, {31'd0, h.jump});
      check("taken", {31'd0, alu_jump_taken}, {31'd0, h.taken});
      check("target", alu_jump_target, h.target);
    end else if (flushed_last) begin
      check("flush_value", alu_cbd_value, 32'd0);
      check("flush_rename", {27'd0, alu_update_rename}, 32'd0);
      check("flush_jump", {30'd0, alu_is_jump, alu_jump_taken}, 32'd0);
      check("flush_target", alu_jump_target, 32'd0);
    end
    flushed_last = rst || jump_wrong;
    if (flushed_last) begin
      exp_q.delete();
    end else if (rdy) begin
      pop = (exp_q.size() != 0) && cdb_grant;
      acc = alu_enable && (exp_q.size() < DEPTH || pop);
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(ref_calc(int'(to_alu_op), to_alu_rs1_value, to_alu_rs2_value,
                                        to_alu_imm, to_alu_pc, to_alu_rd_rename));
    end
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p,
                       input logic [ROB_IDX_W-1:0] tag);
    to_alu_op        = op;
    to_alu_rs1_value = a;
    to_alu_rs2_value = b;
    to_alu_imm       = im;
    to_alu_pc        = p;
    to_alu_rd_rename = tag;
    alu_enable       = 1'b1;
    step();
    alu_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flushed_last = 1'b1;
    rst = 1'b0;

    // ADD latency and single-entry pop
    cdb_grant = 1'b1;
    step();
    issue(6'd1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
    check("t1_bcast", {31'd0, alu_broadcast}, 32'd1);
    check("t1_value", alu_cbd_value, 32'd12);
    check("t1_rename", {27'd0, alu_update_rename}, 32'd3);
    step();
    check("t1_empty", {31'd0, alu_broadcast}, 32'd0);

    // signed vs unsigned branch
    issue(6'd26, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd1);
    check("t2_jump", {31'd0, alu_is_jump}, 32'd1);
    check("t2_taken", {31'd0, alu_jump_taken}, 32'd1);
    check("t2_target", alu_jump_target, 32'h120);
    issue(6'd28, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd2);
    check("t2_bltu_taken", {31'd0, alu_jump_taken}, 32'd0);
    step();

    // back-pressure, dropped third issue, ordered drain
    cdb_grant = 1'b0;
    issue(6'd1, 32'd1, 32'd1, 32'd0, 32'd0, 5'd10);
    issue(6'd2, 32'd9, 32'd1, 32'd0, 32'd0, 5'd11);
    check("t3_full", {31'd0, alu_full}, 32'd1);
    issue(6'd3, 32'd3, 32'd1, 32'd0, 32'd0, 5'd12);
    check("t3_head", {27'd0, alu_update_rename}, 32'd10);
    cdb_grant = 1'b1;
    step();
    check("t3_second", {27'd0, alu_update_rename}, 32'd11);
    step();
    check("t3_drained", {31'd0, alu_broadcast}, 32'd0);

    // push while full with grant, pointer wrap
    cdb_grant = 1'b0;
    issue(6'd11, 32'd100, 32'd0, 32'd1, 32'd0, 5'd1);
    issue(6'd11, 32'd100, 32'd0, 32'd2, 32'd0, 5'd2);
    cdb_grant = 1'b1;
    for (int i = 3; i <= 8; i++) begin
      issue(6'd11, 32'd100, 32'd0, 32'(i), 32'd0, 5'(i));
      check("t4_full_held", {31'd0, alu_full}, 32'd1);
    end
    check("t4_head", {27'd0, alu_update_rename}, 32'd7);
    repeat (3) step();

    // flush with two queued and a concurrent issue
    cdb_grant = 1'b0;
    issue(6'd4, 32'd1, 32'd2, 32'd0, 32'd0, 5'd14);
    issue(6'd5, 32'd1, 32'd2, 32'd0, 32'd0, 5'd15);
    jump_wrong = 1'b1;
    issue(6'd1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd20);
    jump_wrong = 1'b0;
    check("t5_bcast", {31'd0, alu_broadcast}, 32'd0);
    check("t5_full", {31'd0, alu_full}, 32'd0);
    issue(6'd1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd21);
    check("t5_sole", {27'd0, alu_update_rename}, 32'd21);
    cdb_grant = 1'b1;
    step();
    check("t5_empty", {31'd0, alu_broadcast}, 32'd0);

    // SRAI / JALR
    issue(6'd17, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd6);
    check("t6_srai", alu_cbd_value, 32'hF800_0000);
    issue(6'd23, 32'h101, 32'd0, 32'd2, 32'h40, 5'd7);
    check("t6_jalr_value", alu_cbd_value, 32'h44);
    check("t6_jalr_target", alu_jump_target, 32'h102);
    step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rdy              = $urandom_range(0, 7) != 0;
      cdb_grant        = $urandom_range(0, 2) != 0;
      alu_enable       = $urandom_range(0, 3) != 0;
      jump_wrong       = $urandom_range(0, 39) == 0;
      rst              = $urandom_range(0, 149) == 0;
      to_alu_op        = 6'($urandom_range(0, 31));
      to_alu_rs1_value = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      to_alu_rs2_value = ($urandom_range(0, 3) == 0) ? to_alu_rs1_value : $urandom;
      to_alu_imm       = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      to_alu_pc        = $urandom & 32'hFFFF_FFFC;
      to_alu_rd_rename = 5'($urandom);
      step();
    end
    rst        = 1'b0;
    jump_wrong = 1'b0;
    alu_enable = 1'b0;
    rdy        = 1'b1;
    cdb_grant  = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
